matvec_sequencer: RTL and testbench
===================================

# matvec_sequencer

Parametrised control sequencer for the matrix processor datapath. It loads a DIM×DIM matrix and then one DIM-element vector per work item through a valid/ack memory handshake. For each work item it runs DIM×DIM multiply-accumulate cycles with a per-row writeback strobe, and it loops over a programmable work-item count. A loaded matrix can be retained across jobs (matrix reuse mode), and a running job can be aborted.

## Interface
- DIM, 4: matrix dimension; must be ≥2 and a power of two.
- WI_W, 16: width of the work-item counter.
- IDX_W, $clog2(DIM*DIM): width of the element index (derived; do not override).
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- start  in  1  begin a job; sampled in IDLE only.
- wi_count  in  WI_W  number of work items; sampled with start.
- reuse_matrix  in  1  skip the matrix load if a matrix is already valid; sampled with start.
- abort  in  1  synchronous return to IDLE; clears the matrix-valid flag.
- mem_ack  in  1  current element accepted by memory / the register file.
- mem_req  out  1  element transfer request.
- load_matrix  out  1  the request targets the matrix registers.
- load_vector  out  1  the request targets the vector registers.
- elem_index  out  IDX_W  element index: matrix element / vector element / MAC row*DIM+col.
- mac_en  out  1  datapath MAC step.
- acc_clr  out  1  clear the accumulator (first column of each row).
- wb_en  out  1  write the accumulated row result (last column of each row).
- wi_remaining  out  WI_W  work items not yet completed.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at the end of a job.
- matrix_valid  out  1  the matrix registers hold a complete matrix.

## Operation
- States: IDLE, LOAD_MAT, LOAD_VEC, COMPUTE. The state register, index counter, wi_remaining, matrix_valid and done are flops. All other outputs are decoded combinationally from state and counter.
- IDLE, start=1, wi_count=0: no transfers; done pulses on the next cycle; remain in IDLE.
- IDLE, start=1, wi_count≠0: latch wi_remaining=wi_count and clear the index counter.
  - Go to LOAD_VEC if reuse_matrix=1 and matrix_valid=1.
  - Otherwise go to LOAD_MAT and clear matrix_valid.
- LOAD_MAT: mem_req=load_matrix=1, elem_index=counter.
  - The counter advances only on mem_ack.
  - Ack at index DIM*DIM-1: set matrix_valid, counter wraps to 0, go to LOAD_VEC.
- LOAD_VEC: mem_req=load_vector=1, elem_index=counter (0..DIM-1).
  - The counter advances on ack.
  - Ack at index DIM-1: counter to 0, go to COMPUTE.
- COMPUTE: mac_en=1 every cycle, elem_index=counter, counter increments unconditionally.
  - acc_clr=1 when the column bits (index mod DIM) are 0.
  - wb_en=1 when the column bits equal DIM-1.
  - At index DIM*DIM-1: decrement wi_remaining and counter to 0.
    - If the new value is 0: go to IDLE and pulse done next cycle.
    - Otherwise: go to LOAD_VEC (the matrix is reused within the job).
- mem_req stays high until acked. The index must not change while a request is pending.
- abort has the highest priority after reset, in any state:
  - next state IDLE, counter 0, matrix_valid 0, wi_remaining 0, no done pulse.
  - Outputs in the abort cycle still reflect the current state. A transfer acked in that cycle is discarded.
- start while busy is ignored. start and abort together in IDLE: abort wins and no job starts.

## Timing
- Reset values: state IDLE, all strobes 0, elem_index 0, wi_remaining 0, matrix_valid 0, done 0, busy 0.
- start is registered. The first mem_req is in the cycle after start.
- With mem_ack tied high:
  - LOAD_MAT takes DIM*DIM cycles.
  - LOAD_VEC takes DIM cycles.
  - COMPUTE takes DIM*DIM cycles.
- done is high for exactly one cycle, the cycle after the final COMPUTE cycle, when busy is already 0. A new start is accepted in that same cycle.
- Reset asserted mid-job: all state returns to reset values on the next clk edge, including matrix_valid.
- Counter arithmetic is IDX_W bits and wraps naturally at DIM*DIM. Vector indices compare against DIM-1 explicitly. wi_remaining never underflows.

## Test plan
- DIM=4, wi_count=2, mem_ack=1, start at cycle 0 -> LOAD_MAT 1–16, LOAD_VEC 17–20, COMPUTE 21–36 (wb_en at 24, 28, 32, 36), LOAD_VEC 37–40, COMPUTE 41–56, done=1 at 57 only; matrix_valid=1 afterwards.
- Immediate second job with reuse_matrix=1, wi_count=1 -> no load_matrix; 4 vector requests then 16 MACs; done 21 cycles after start.
- Random mem_ack with 30% ack probability during loads -> elem_index holds while un-acked; exactly 16 matrix and 4 vector acks per item; no MAC until the 4th vector ack.
- start with wi_count=0 -> no mem_req, done pulses the next cycle, busy stays 0.
- abort at COMPUTE index 7 -> IDLE next cycle, matrix_valid=0, no done; following start with reuse_matrix=1 still performs the full matrix load.
- rst_n low for 1 cycle during LOAD_MAT index 5 -> all outputs at reset values; start pulses during busy cycles are ignored (wi_remaining unchanged).

Source files
------------

// File: rtl/matvec_sequencer.sv
// Control sequencer for the matrix processor: loads a DIMxDIM matrix, then per work item
// loads a DIM-element vector and steps the MAC datapath row by row with writeback strobes.
module matvec_sequencer #(
  parameter int DIM   = 4,
  parameter int WI_W  = 16,
  parameter int IDX_W = $clog2(DIM*DIM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WI_W-1:0]  wi_count,
  input  logic             reuse_matrix,
  input  logic             abort,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             load_matrix,
  output logic             load_vector,
  output logic [IDX_W-1:0] elem_index,
  output logic             mac_en,
  output logic             acc_clr,
  output logic             wb_en,
  output logic [WI_W-1:0]  wi_remaining,
  output logic             busy,
  output logic             done,
  output logic             matrix_valid
);

  localparam int COL_W = $clog2(DIM);
  localparam logic [IDX_W-1:0] LAST_ELEM = IDX_W'(DIM*DIM-1);
  localparam logic [IDX_W-1:0] LAST_VEC  = IDX_W'(DIM-1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(DIM-1);

  typedef enum logic [1:0] {IDLE, LOAD_MAT, LOAD_VEC, COMPUTE} state_t;

  state_t           r_state, w_stateNext;
  logic [IDX_W-1:0] r_idx, w_idxNext;
  logic [WI_W-1:0]  r_wiRem, w_wiRemNext, w_wiDec;
  logic             r_matValid, w_matValidNext;
  logic             r_done, w_doneNext;
  logic [COL_W-1:0] w_col;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_wiRem    <= '0;
      r_matValid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_idx      <= w_idxNext;
      r_wiRem    <= w_wiRemNext;
      r_matValid <= w_matValidNext;
      r_done     <= w_doneNext;
    end
  end

  // Saturating decrement keeps wi_remaining from ever wrapping below zero.
  assign w_wiDec = (r_wiRem != '0) ? (r_wiRem - WI_W'(1)) : '0;

  always_comb begin
    w_stateNext    = r_state;
    w_idxNext      = r_idx;
    w_wiRemNext    = r_wiRem;
    w_matValidNext = r_matValid;
    w_doneNext     = 1'b0;
    if (abort) begin
      w_stateNext    = IDLE;
      w_idxNext      = '0;
      w_wiRemNext    = '0;
      w_matValidNext = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (wi_count == '0) begin
              w_doneNext = 1'b1;
            end else begin
              w_wiRemNext = wi_count;
              w_idxNext   = '0;
              if (reuse_matrix && r_matValid) begin
                w_stateNext = LOAD_VEC;
              end else begin
                w_stateNext    = LOAD_MAT;
                w_matValidNext = 1'b0;
              end
            end
          end
        end
        LOAD_MAT: begin
          if (mem_ack) begin
            w_idxNext = r_idx + IDX_W'(1);
            if (r_idx == LAST_ELEM) begin
              w_idxNext      = '0;
              w_matValidNext = 1'b1;
              w_stateNext    = LOAD_VEC;
            end
          end
        end
        LOAD_VEC: begin
          if (mem_ack) begin
            w_idxNext = r_idx + IDX_W'(1);
            if (r_idx == LAST_VEC) begin
              w_idxNext   = '0;
              w_stateNext = COMPUTE;
            end
          end
        end
        COMPUTE: begin
          w_idxNext = r_idx + IDX_W'(1);
          if (r_idx == LAST_ELEM) begin
            w_idxNext   = '0;
            w_wiRemNext = w_wiDec;
            if (w_wiDec == '0) begin
              w_stateNext = IDLE;
              w_doneNext  = 1'b1;
            end else begin
              w_stateNext = LOAD_VEC;
            end
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  assign w_col        = r_idx[COL_W-1:0];
  assign load_matrix  = (r_state == LOAD_MAT);
  assign load_vector  = (r_state == LOAD_VEC);
  assign mem_req      = load_matrix || load_vector;
  assign mac_en       = (r_state == COMPUTE);
  assign acc_clr      = mac_en && (w_col == '0);
  assign wb_en        = mac_en && (w_col == LAST_COL);
  assign elem_index   = r_idx;
  assign busy         = (r_state != IDLE);
  assign wi_remaining = r_wiRem;
  assign done         = r_done;
  assign matrix_valid = r_matValid;

endmodule

// File: tb/tb_matvec_sequencer.sv
// Scoreboard bench for matvec_sequencer: each job pushes its expected transfer/MAC/done
// event stream, and a negedge monitor pops and compares every event the DUT produces.
module tb_matvec_sequencer;

  localparam int DIM   = 4;
  localparam int WI_W  = 16;
  localparam int IDX_W = 4;
  localparam int EV_VEC  = 256;
  localparam int EV_MAT  = 512;
  localparam int EV_MAC  = 1024;
  localparam int EV_DONE = 1280;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WI_W-1:0]  wi_count = '0;
  logic             reuse_matrix = 1'b0;
  logic             abort = 1'b0;
  logic             mem_ack = 1'b1;
  logic             mem_req, load_matrix, load_vector, mac_en, acc_clr, wb_en;
  logic             busy, done, matrix_valid;
  logic [IDX_W-1:0] elem_index;
  logic [WI_W-1:0]  wi_remaining;

  typedef struct {int code; int cyc;} ev_t;
  ev_t expQ[$];

  int vecCount = 0;
  int missCount = 0;
  int cycNum = 0;
  int ackPct = 100;
  bit monOn = 1'b0;
  bit holdPending = 1'b0;
  logic [IDX_W-1:0] holdIdx = '0;

  matvec_sequencer #(.DIM(DIM), .WI_W(WI_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wi_count(wi_count),
    .reuse_matrix(reuse_matrix), .abort(abort), .mem_ack(mem_ack),
    .mem_req(mem_req), .load_matrix(load_matrix), .load_vector(load_vector),
    .elem_index(elem_index), .mac_en(mac_en), .acc_clr(acc_clr), .wb_en(wb_en),
    .wi_remaining(wi_remaining), .busy(busy), .done(done), .matrix_valid(matrix_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycNum <= cycNum + 1;

  // Memory side acknowledges with a programmable percentage chance each cycle.
  always @(posedge clk) begin
    #1;
    mem_ack = (int'($urandom_range(0, 99)) < ackPct);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cycNum);
    end
  endtask

  task automatic pushEv(input int code, input int cyc);
    ev_t e;
    e.code = code;
    e.cyc  = cyc;
    expQ.push_back(e);
  endtask

  task automatic consume(input int code);
    ev_t e;
    if (expQ.size() == 0) begin
      checkOutput("unexpectedEvent", code, 0);
    end else begin
      e = expQ.pop_front();
      checkOutput("event", code, e.code);
      if (e.cyc >= 0) checkOutput("eventCycle", cycNum, e.cyc);
    end
  endtask

  // Expected event stream of one job; cycle stamps only when mem_ack is tied high.
  task automatic pushJob(input int wi, input bit loadMat, input bit timed, input int t0);
    int c;
    int mac;
    c = t0 + 1;
    if (wi != 0) begin
      if (loadMat) begin
        for (int i = 0; i < DIM*DIM; i++) begin
          pushEv(EV_MAT + i, timed ? c : -1);
          c++;
        end
      end
      for (int w = 0; w < wi; w++) begin
        for (int v = 0; v < DIM; v++) begin
          pushEv(EV_VEC + v, timed ? c : -1);
          c++;
        end
        for (int m = 0; m < DIM*DIM; m++) begin
          mac = EV_MAC + m + ((m % DIM == 0) ? 128 : 0) + ((m % DIM == DIM-1) ? 64 : 0);
          pushEv(mac, timed ? c : -1);
          c++;
        end
      end
    end
    pushEv(EV_DONE, timed ? c : -1);
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      if (holdPending && mem_req) checkOutput("idxHold", 32'(elem_index), 32'(holdIdx));
      if (mem_req && mem_ack) consume(int'({load_matrix, load_vector}) * 256 + int'(elem_index));
      if (mac_en) consume(EV_MAC + (acc_clr ? 128 : 0) + (wb_en ? 64 : 0) + int'(elem_index));
      if (done) consume(EV_DONE);
      holdPending = mem_req && !mem_ack;
      holdIdx = elem_index;
    end
  end

  function automatic logic [31:0] outVec();
    return {3'b000, mem_req, load_matrix, load_vector, mac_en, acc_clr, wb_en,
            busy, done, matrix_valid, elem_index, wi_remaining};
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after start.
  task automatic applyStimulus(input int wi, input bit reuse, input bit expMat, input bit timed);
    pushJob(wi, expMat, timed, cycNum);
    start = 1'b1;
    wi_count = WI_W'(wi);
    reuse_matrix = reuse;
    @(posedge clk); #1;
    start = 1'b0;
    if (wi != 0) checkOutput("wiLatched", 32'(wi_remaining), wi);
    else checkOutput("busyZeroJob", 32'(busy), 0);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (done !== 1'b1) checkOutput("doneTimeout", 0, 1);
  endtask

  task automatic checkDrained();
    @(negedge clk); #1;
    checkOutput("queueDrained", expQ.size(), 0);
    expQ.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetState", outVec(), 0);
    rst_n = 1'b1;
    monOn = 1'b1;
    @(posedge clk); #1;

    // Two work items with full matrix load, then an immediate reuse job in the done cycle.
    applyStimulus(2, 1'b0, 1'b1, 1'b1);
    waitDone();
    checkOutput("busyAtDone", 32'(busy), 0);
    checkOutput("matValidAfterJob", 32'(matrix_valid), 1);
    applyStimulus(1, 1'b1, 1'b0, 1'b1);
    waitDone();
    checkDrained();

    // Zero work items: only a done pulse, never busy.
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    waitDone();
    checkOutput("busyZeroDone", 32'(busy), 0);
    checkDrained();

    // Sparse acknowledges during loads.
    ackPct = 30;
    applyStimulus(2, 1'b0, 1'b1, 1'b0);
    waitDone();
    ackPct = 100;
    checkDrained();
    checkOutput("matValidRandom", 32'(matrix_valid), 1);

    // Abort in the middle of COMPUTE, then a reuse request must reload the matrix.
    applyStimulus(1, 1'b0, 1'b1, 1'b1);
    n = 0;
    while (!(mac_en && elem_index == IDX_W'(7)) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("abortReached", 32'(mac_en && elem_index == IDX_W'(7)), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    expQ.delete();
    checkOutput("abortBusy", 32'(busy), 0);
    checkOutput("abortMatValid", 32'(matrix_valid), 0);
    checkOutput("abortWiRem", 32'(wi_remaining), 0);
    checkOutput("abortDone", 32'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(1, 1'b1, 1'b1, 1'b1);
    waitDone();
    checkDrained();

    // Busy-time start is ignored, then a one-cycle reset during the matrix load.
    applyStimulus(2, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    start = 1'b1;
    wi_count = WI_W'(9);
    reuse_matrix = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("startIgnoredWi", 32'(wi_remaining), 2);
    checkOutput("startIgnoredLoad", 32'(load_matrix), 1);
    n = 0;
    while (!(load_matrix && elem_index == IDX_W'(5)) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("rstReached", 32'(load_matrix && elem_index == IDX_W'(5)), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    expQ.delete();
    checkOutput("midJobReset", outVec(), 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idleAfterReset", outVec(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
